// File: rtl/alu_tb_pkg.sv
// Shared definitions for the ALU vector generator: LFSR polynomial, corner count,
// mode encodings, FSM state type and small helper functions.
package alu_tb_pkg;

    // Galois right-shift feedback taps
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Number of fixed corner vectors at the start of a run
    localparam int unsigned NUM_CORNERS = 4;

    // Operation mode encodings
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_CMP = 2'b10;
    localparam logic [1:0] MODE_ROT = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpCmp = 2'd2
    } op_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and advance enable.
module lfsr32
    import alu_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] seed_eff;

    assign seed_eff = seed_fix(seed);

    // Load wins over advance so a restart always begins from the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed_eff;
        end else if (load) begin
            state <= seed_eff;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/alu_vector_gen.sv
// ALU stimulus generator: emits a run of operand/expected-result vectors with a
// valid/ready handshake. Optional corner vectors lead each run, then two LFSRs
// supply the operands. All outputs are registered.
module alu_vector_gen
    import alu_tb_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_B      = 32'h0000_ACE1,
    parameter int unsigned CORNERS     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [WIDTH:0]   result,
    output logic             add,
    output logic             sub,
    output logic             cmp,
    output logic             busy,
    output logic             done
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    state_e           state_q;
    logic [15:0]      idx_q;
    logic [1:0]       rot_q;      // idx_q mod 3, tracked incrementally
    logic [31:0]      lfsr_a;
    logic [31:0]      lfsr_b;

    logic             start_load;
    logic             accept;
    logic             last_vec;
    logic             cur_corner;
    logic             lfsr_adv;

    logic [15:0]      nxt_idx;
    logic [1:0]       nxt_rot;
    logic             nxt_corner;
    logic [31:0]      src_a;
    logic [31:0]      src_b;
    logic [WIDTH-1:0] nxt_op1;
    logic [WIDTH-1:0] nxt_op2;
    op_e              nxt_op;
    logic [WIDTH:0]   nxt_result;

    function automatic logic is_corner(input logic [15:0] idx);
        return (CORNERS != 0) && (idx < 16'(NUM_CORNERS));
    endfunction

    lfsr32 u_lfsr_a (
        .clk     (clk),
        .rst     (rst),
        .seed    (SEED_A),
        .load    (start_load),
        .advance (lfsr_adv),
        .state   (lfsr_a)
    );

    lfsr32 u_lfsr_b (
        .clk     (clk),
        .rst     (rst),
        .seed    (SEED_B),
        .load    (start_load),
        .advance (lfsr_adv),
        .state   (lfsr_b)
    );

    // Handshake and control decode
    always_comb begin
        start_load = start && (state_q != StRun);
        accept     = valid && ready;
        last_vec   = (idx_q == LAST_IDX);
        cur_corner = is_corner(idx_q);
        // LFSR state is the operand source of the vector on the outputs, so it
        // only moves once a random vector has been consumed
        lfsr_adv   = accept && !cur_corner;
    end

    // Build the vector that will be loaded at the next load edge
    always_comb begin
        nxt_idx    = start_load ? 16'd0 : idx_q + 16'd1;
        nxt_rot    = (start_load || (rot_q == 2'd2)) ? 2'd0 : rot_q + 2'd1;
        nxt_corner = is_corner(nxt_idx);

        // The LFSRs reload in the same edge as start, so read the seeds directly
        if (start_load) begin
            src_a = seed_fix(SEED_A);
            src_b = seed_fix(SEED_B);
        end else if (cur_corner) begin
            src_a = lfsr_a;
            src_b = lfsr_b;
        end else begin
            src_a = lfsr_next(lfsr_a);
            src_b = lfsr_next(lfsr_b);
        end

        nxt_op1 = src_a[WIDTH-1:0];
        nxt_op2 = src_b[WIDTH-1:0];
        if (nxt_corner) begin
            unique case (nxt_idx[1:0])
                2'd0: begin
                    nxt_op1 = '0;
                    nxt_op2 = '0;
                end
                2'd1: begin
                    nxt_op1 = '1;
                    nxt_op2 = WIDTH'(1);
                end
                2'd2: begin
                    nxt_op1 = '1;
                    nxt_op2 = '1;
                end
                default: begin
                    nxt_op1 = '0;
                    nxt_op2 = WIDTH'(1);
                end
            endcase
        end

        unique case (mode)
            MODE_ADD: nxt_op = OpAdd;
            MODE_SUB: nxt_op = OpSub;
            MODE_CMP: nxt_op = OpCmp;
            default: begin
                unique case (nxt_rot)
                    2'd0:    nxt_op = OpAdd;
                    2'd1:    nxt_op = OpSub;
                    default: nxt_op = OpCmp;
                endcase
            end
        endcase

        if (nxt_op == OpAdd) begin
            nxt_result = {1'b0, nxt_op1} + {1'b0, nxt_op2};
        end else begin
            nxt_result = {1'b0, nxt_op1} - {1'b0, nxt_op2};
        end
    end

    // Run FSM with registered vector outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rot_q   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            op1     <= '0;
            op2     <= '0;
            result  <= '0;
            add     <= 1'b0;
            sub     <= 1'b0;
            cmp     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        idx_q   <= nxt_idx;
                        rot_q   <= nxt_rot;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        op1     <= nxt_op1;
                        op2     <= nxt_op2;
                        result  <= nxt_result;
                        add     <= (nxt_op == OpAdd);
                        sub     <= (nxt_op == OpSub);
                        cmp     <= (nxt_op == OpCmp);
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (last_vec) begin
                            state_q <= StDone;
                            valid   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            op1     <= '0;
                            op2     <= '0;
                            result  <= '0;
                            add     <= 1'b0;
                            sub     <= 1'b0;
                            cmp     <= 1'b0;
                        end else begin
                            idx_q   <= nxt_idx;
                            rot_q   <= nxt_rot;
                            op1     <= nxt_op1;
                            op2     <= nxt_op2;
                            result  <= nxt_result;
                            add     <= (nxt_op == OpAdd);
                            sub     <= (nxt_op == OpSub);
                            cmp     <= (nxt_op == OpCmp);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vector_gen.sv
// Directed bench for alu_vector_gen: a 32-bit random-only instance and an 8-bit
// instance with corner vectors, driven from one linear initial block.
module tb_alu_vector_gen;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, ready_a;
    logic [1:0]  mode_a;
    logic        valid_a, add_a, sub_a, cmp_a, busy_a, done_a;
    logic [31:0] op1_a, op2_a;
    logic [32:0] res_a;

    logic        start_b, ready_b;
    logic [1:0]  mode_b;
    logic        valid_b, add_b, sub_b, cmp_b, busy_b, done_b;
    logic [7:0]  op1_b, op2_b;
    logic [8:0]  res_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] ea1 [16];
    logic [31:0] ea2 [16];

    // 8-bit instance, corners on, 6 vectors: seeds give 0x01/0xE1 then 0x03/0x73
    logic [7:0] b_op1     [6] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h03};
    logic [7:0] b_op2     [6] = '{8'h00, 8'h01, 8'hFF, 8'h01, 8'hE1, 8'h73};
    logic [8:0] b_sub_res [6] = '{9'h000, 9'h0FE, 9'h000, 9'h1FF, 9'h120, 9'h190};
    logic [8:0] b_rot_res [6] = '{9'h000, 9'h0FE, 9'h000, 9'h001, 9'h120, 9'h190};
    logic [2:0] b_rot_stb [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};

    always #5 clk = ~clk;

    alu_vector_gen #(
        .WIDTH       (32),
        .NUM_VECTORS (16),
        .SEED_A      (32'h0000_0001),
        .SEED_B      (32'h0000_ACE1),
        .CORNERS     (0)
    ) u_a (
        .clk    (clk),
        .rst    (rst),
        .start  (start_a),
        .mode   (mode_a),
        .ready  (ready_a),
        .valid  (valid_a),
        .op1    (op1_a),
        .op2    (op2_a),
        .result (res_a),
        .add    (add_a),
        .sub    (sub_a),
        .cmp    (cmp_a),
        .busy   (busy_a),
        .done   (done_a)
    );

    alu_vector_gen #(
        .WIDTH       (8),
        .NUM_VECTORS (6),
        .SEED_A      (32'h0000_0001),
        .SEED_B      (32'h0000_ACE1),
        .CORNERS     (1)
    ) u_b (
        .clk    (clk),
        .rst    (rst),
        .start  (start_b),
        .mode   (mode_b),
        .ready  (ready_b),
        .valid  (valid_b),
        .op1    (op1_b),
        .op2    (op2_b),
        .result (res_b),
        .add    (add_b),
        .sub    (sub_b),
        .cmp    (cmp_b),
        .busy   (busy_b),
        .done   (done_b)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec_a(input string tag, input int k);
        logic [32:0] er;
        er = {1'b0, ea1[k]} + {1'b0, ea2[k]};
        chk($sformatf("%s_valid[%0d]", tag, k), valid_a, 1);
        chk($sformatf("%s_op1[%0d]", tag, k), op1_a, ea1[k]);
        chk($sformatf("%s_op2[%0d]", tag, k), op2_a, ea2[k]);
        chk($sformatf("%s_result[%0d]", tag, k), res_a, er);
        chk($sformatf("%s_strobes[%0d]", tag, k), {add_a, sub_a, cmp_a}, 3'b100);
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_op1"}, op1_a, 0);
        chk({tag, "_op2"}, op2_a, 0);
        chk({tag, "_result"}, res_a, 0);
        chk({tag, "_strobes"}, {add_a, sub_a, cmp_a}, 0);
    endtask

    initial begin
        ea1[0] = 32'h0000_0001;
        ea2[0] = 32'h0000_ACE1;
        for (int i = 1; i < 16; i++) begin
            ea1[i] = lfsr_step(ea1[i-1]);
            ea2[i] = lfsr_step(ea2[i-1]);
        end

        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b0; mode_a = 2'b00;
        start_b = 1'b0; ready_b = 1'b0; mode_b = 2'b00;
        repeat (2) @(negedge clk);
        check_idle_a("reset");
        chk("reset_b_valid", valid_b, 0);
        rst = 1'b0;

        // No run without a start pulse
        repeat (2) @(negedge clk);
        check_idle_a("idle_no_start");

        // Random-only run, add mode, with a stall and a stray start mid-run
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_vec_a("run1", k);
            chk($sformatf("run1_busy[%0d]", k), busy_a, 1);
            if (k == 0) chk("v0_result_const", res_a, 33'h0_0000_ACE2);
            if (k == 1) begin
                chk("v1_op1_const", op1_a, 32'h8020_0003);
                chk("v1_op2_const", op2_a, 32'h8020_5673);
                chk("v1_result_const", res_a, 33'h1_0040_5676);
            end
            if (k == 4) begin
                ready_a = 1'b0;
                mode_a  = 2'b01;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check_vec_a($sformatf("stall%0d", s), k);
                end
                mode_a  = 2'b00;
                ready_a = 1'b1;
            end
            if (k == 7) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        check_vec_a("pre_rst", 10);

        // Reset in the middle of a run clears outputs immediately
        rst = 1'b1;
        #1;
        check_idle_a("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_a("post_rst");

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_vec_a("run2", k);
            @(negedge clk);
        end
        chk("run2_done", done_a, 1);
        chk("run2_busy_fall", busy_a, 0);
        chk("run2_valid_fall", valid_a, 0);
        chk("run2_strobes_off", {add_a, sub_a, cmp_a}, 0);
        @(negedge clk);
        chk("run2_done_hold", done_a, 1);

        // Restart from DONE clears done and replays vector 0
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ready_a = 1'b0;
        chk("rerun_done_clr", done_a, 0);
        check_vec_a("rerun", 0);

        // 8-bit corner run, subtract mode
        mode_b  = 2'b01;
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sub_op1[%0d]", k), op1_b, b_op1[k]);
            chk($sformatf("sub_op2[%0d]", k), op2_b, b_op2[k]);
            chk($sformatf("sub_result[%0d]", k), res_b, b_sub_res[k]);
            chk($sformatf("sub_strobes[%0d]", k), {add_b, sub_b, cmp_b}, 3'b010);
            @(negedge clk);
        end
        chk("sub_done", done_b, 1);
        chk("sub_busy", busy_b, 0);

        // Rotating mode: add, sub, cmp by index
        mode_b  = 2'b11;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("rot_done_clr", done_b, 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rot_busy[%0d]", k), busy_b, 1);
            chk($sformatf("rot_op1[%0d]", k), op1_b, b_op1[k]);
            chk($sformatf("rot_op2[%0d]", k), op2_b, b_op2[k]);
            chk($sformatf("rot_result[%0d]", k), res_b, b_rot_res[k]);
            chk($sformatf("rot_strobes[%0d]", k), {add_b, sub_b, cmp_b}, b_rot_stb[k]);
            @(negedge clk);
        end
        chk("rot_done", done_b, 1);
        chk("rot_busy_fall", busy_b, 0);
        chk("rot_valid_fall", valid_b, 0);
        chk("rot_strobes_off", {add_b, sub_b, cmp_b}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_vector_gen.md
ALU_VECTOR_GEN -- requirements
Module: alu_vector_gen

Interface
REQ-001 Parameter WIDTH, 32, operand width; legal range 4..32.
REQ-002 Parameter NUM_VECTORS, 256, vectors per run; legal range 1..65535.
REQ-003 Parameter SEED_A, 32'h0000_0001, initial state of the op1 LFSR.
REQ-004 Parameter SEED_B, 32'h0000_ACE1, initial state of the op2 LFSR.
REQ-005 Parameter CORNERS, 1, when 1 the first four vectors of a run are fixed corner cases.
REQ-006 clk  in  1  single clock; all state updates on posedge clk.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 start  in  1  one-cycle pulse that begins a run.
REQ-009 mode  in  2  00 add only, 01 sub only, 10 cmp only, 11 rotate add/sub/cmp.
REQ-010 ready  in  1  consumer accepts the current vector.
REQ-011 valid  out  1  op1/op2/result/add/sub/cmp hold a vector.
REQ-012 op1, op2  out  WIDTH each  operands.
REQ-013 result  out  WIDTH+1  expected result.
REQ-014 add, sub, cmp  out  1 each  operation strobes.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  level, high after the last vector is accepted until the next start or rst.

Function
REQ-017 FSM states: IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on acceptance of vector NUM_VECTORS-1, DONE->RUN on start.
REQ-018 start in RUN is ignored; start in IDLE or DONE reloads both LFSRs from their seeds, clears the vector index, and clears done.
REQ-019 valid is high in every RUN cycle, starting with the cycle after start; busy equals (state==RUN).
REQ-020 A vector is accepted in a cycle when valid and ready are both high; the index and LFSRs advance only on acceptance.
REQ-021 While valid && !ready, all vector outputs hold stable.
REQ-022 LFSRs are 32-bit Galois, right-shift; next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
REQ-023 A seed of zero is replaced by 32'h1 on load.
REQ-024 Random vectors: op1 = LFSR_A[WIDTH-1:0] and op2 = LFSR_B[WIDTH-1:0].
REQ-025 When CORNERS=1, vectors at indices 0..3 are (0,0), (all-ones,1), (all-ones,all-ones), (0,1); LFSRs do not advance during these indices.
REQ-026 When NUM_VECTORS<4, only the first NUM_VECTORS corner vectors are issued.
REQ-027 Operation select: the mode value, or for mode 11 the index mod 3 (0 add, 1 sub, 2 cmp).
REQ-028 Exactly one of add/sub/cmp is high while valid; all three are 0 when valid is low.
REQ-029 mode is sampled per vector at index load; a mode change under a stalled vector does not alter it.
REQ-030 result: add -> zero-extended op1 + op2, with carry in bit WIDTH.
REQ-031 result: sub and cmp -> {1'b0,op1} - {1'b0,op2} modulo 2^(WIDTH+1), with borrow in bit WIDTH.
REQ-032 Outputs are registered; no combinational path runs from ready or start to any output.

Reset
REQ-033 rst forces IDLE, LFSRs to their seeds (zero replaced by 1), index 0, and all outputs 0; this applies at any time, including mid-run and during a stall.
REQ-034 After rst deasserts, the first run starts only on a start pulse.

Structure
REQ-035 The polynomial constant, the corner-vector count (4), the mode encodings and the FSM state type live in the shared package alu_tb_pkg.
REQ-036 The LFSR is one sub-module, lfsr32 (seed, load, advance, state), instantiated twice.

Verification
REQ-037 WIDTH=32, CORNERS=0, mode=00, ready=1, start -> vector 0: op1=0x00000001, op2=0x0000ACE1, result=0x0_0000ACE2, add=1; vector 1: op1=0x80200003, op2=0x80205673, result=0x1_00405676.
REQ-038 WIDTH=8, CORNERS=1, mode=01 -> vectors 0..3 give results 0x000, 0x0FE, 0x000, 0x1FF, each with sub=1.
REQ-039 mode=11, NUM_VECTORS=6 -> strobes add,sub,cmp,add,sub,cmp; done rises the cycle after the 6th acceptance, and busy falls at the same time.
REQ-040 ready held low for 5 cycles mid-run -> outputs are unchanged over the stall and no vector is skipped or repeated.
REQ-041 rst asserted at index 10, then start -> outputs are 0 during rst and the run restarts from vector 0 with identical values.
REQ-042 start pulsed during RUN -> ignored, and the vector sequence is uninterrupted.
